// File: rtl/mem_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_lsu
// Brief    : Memory-access stage; serialises B/H/W loads and stores onto a
//            byte-wide synchronous data memory and stalls upstream meanwhile.
// Revision : 1.0
// ============================================================================
module mem_lsu #(
    parameter int ADDR_W     = 17,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [1:0]            mem_op_i,
    input  logic [2:0]            func3_i,
    input  logic [31:0]           mem_addr_i,
    input  logic [31:0]           store_data_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [31:0]           wdata_i,
    output logic                  valid_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [31:0]           wdata_o,
    output logic                  stall_req_o,
    output logic [ADDR_W-1:0]     mem_a_o,
    output logic [7:0]            mem_dout_o,
    output logic                  mem_wr_o,
    input  logic [7:0]            mem_din_i
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RD    = 2'd1;
    localparam logic [1:0] c_ST_WR    = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [1:0] c_OP_LOAD  = 2'b01;
    localparam logic [1:0] c_OP_STORE = 2'b10;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [2:0]            r_cnt;
    logic [2:0]            r_n;
    logic [ADDR_W-1:0]     r_addr;
    logic [31:0]           r_sdata;
    logic [2:0]            r_func3;
    logic [REG_ADDR_W-1:0] r_lwd;
    logic                  r_lwreg;
    logic [31:0]           r_buf;
    logic                  r_valid;
    logic [REG_ADDR_W-1:0] r_wd;
    logic                  r_wreg;
    logic [31:0]           r_wdata;

    logic                  w_is_load;
    logic                  w_is_store;
    logic                  w_ld_ok;
    logic                  w_st_ok;
    logic                  w_mem_ok;
    logic                  w_unsup;
    logic [2:0]            w_bytes;
    logic                  w_last_rd;
    logic                  w_last_wr;
    logic [1:0]            w_k;
    logic [1:0]            w_cap_idx;
    logic [31:0]           w_cap;
    logic [31:0]           w_ld_data;
    logic                  w_unused;

    assign w_unused = ^mem_addr_i[31:ADDR_W];

    // Instruction decode
    assign w_is_load  = (mem_op_i == c_OP_LOAD);
    assign w_is_store = (mem_op_i == c_OP_STORE);
    assign w_ld_ok    = w_is_load && (func3_i == 3'b000 || func3_i == 3'b001 ||
                                      func3_i == 3'b010 || func3_i == 3'b100 ||
                                      func3_i == 3'b101);
    assign w_st_ok    = w_is_store && (func3_i[2] == 1'b0) && (func3_i[1:0] != 2'b11);
    assign w_mem_ok   = w_ld_ok || w_st_ok;
    assign w_unsup    = (w_is_load && !w_ld_ok) || (w_is_store && !w_st_ok);

    always_comb begin
        case (func3_i[1:0])
            2'b00:   w_bytes = 3'd1;
            2'b01:   w_bytes = 3'd2;
            default: w_bytes = 3'd4;
        endcase
    end

    // Reads take one extra cycle: the last byte returns a cycle after its address
    assign w_last_rd = (r_state == c_ST_RD) && (r_cnt == r_n);
    assign w_last_wr = (r_state == c_ST_WR) && (r_cnt == (r_n - 3'd1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (valid_i && w_mem_ok) begin
                    w_state_nxt = w_ld_ok ? c_ST_RD : c_ST_WR;
                end
            end
            c_ST_RD:   if (w_last_rd) w_state_nxt = c_ST_DONE;
            c_ST_WR:   if (w_last_wr) w_state_nxt = c_ST_DONE;
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_k         = (r_cnt == r_n) ? 2'(r_n - 3'd1) : r_cnt[1:0];
        stall_req_o = rst && (((r_state == c_ST_IDLE) && valid_i && w_mem_ok) ||
                              (r_state == c_ST_RD) || (r_state == c_ST_WR));
        mem_a_o     = '0;
        mem_dout_o  = 8'h00;
        mem_wr_o    = 1'b0;
        if (r_state == c_ST_RD || r_state == c_ST_WR) begin
            mem_a_o = r_addr + ADDR_W'(w_k);
        end
        if (r_state == c_ST_WR) begin
            mem_dout_o = r_sdata[{w_k, 3'b000} +: 8];
            mem_wr_o   = 1'b1;
        end
    end

    // Little-endian byte assembly: byte k arrives while r_cnt == k+1
    always_comb begin
        w_cap_idx = 2'(r_cnt - 3'd1);
        w_cap     = r_buf;
        w_cap[{w_cap_idx, 3'b000} +: 8] = mem_din_i;
        case (r_func3)
            3'b000:  w_ld_data = {{24{w_cap[7]}}, w_cap[7:0]};
            3'b001:  w_ld_data = {{16{w_cap[15]}}, w_cap[15:0]};
            3'b100:  w_ld_data = {24'h000000, w_cap[7:0]};
            3'b101:  w_ld_data = {16'h0000, w_cap[15:0]};
            default: w_ld_data = w_cap;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= 3'd0;
            r_n     <= 3'd0;
            r_addr  <= '0;
            r_sdata <= 32'h0;
            r_func3 <= 3'd0;
            r_lwd   <= '0;
            r_lwreg <= 1'b0;
            r_buf   <= 32'h0;
            r_valid <= 1'b0;
            r_wd    <= '0;
            r_wreg  <= 1'b0;
            r_wdata <= 32'h0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (valid_i) begin
                        if (w_mem_ok) begin
                            r_addr  <= mem_addr_i[ADDR_W-1:0];
                            r_sdata <= store_data_i;
                            r_func3 <= func3_i;
                            r_lwd   <= wd_i;
                            r_lwreg <= wreg_i;
                            r_n     <= w_bytes;
                            r_cnt   <= 3'd0;
                            r_buf   <= 32'h0;
                        end else begin
                            r_valid <= 1'b1;
                            r_wd    <= wd_i;
                            r_wreg  <= wreg_i && !w_unsup;
                            r_wdata <= wdata_i;
                        end
                    end
                end
                c_ST_RD: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt != 3'd0) begin
                        r_buf <= w_cap;
                    end
                    if (w_last_rd) begin
                        r_valid <= 1'b1;
                        r_wd    <= r_lwd;
                        r_wreg  <= r_lwreg;
                        r_wdata <= w_ld_data;
                    end
                end
                c_ST_WR: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (w_last_wr) begin
                        r_valid <= 1'b1;
                        r_wd    <= r_lwd;
                        r_wreg  <= 1'b0;
                        r_wdata <= 32'h0;
                    end
                end
                default: begin
                    r_cnt <= 3'd0;
                end
            endcase
        end
    end

    assign valid_o = r_valid;
    assign wd_o    = r_wd;
    assign wreg_o  = r_wreg;
    assign wdata_o = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_lsu
// Brief    : Directed plus randomised checks of mem_lsu against a byte-array
//            memory model and per-instruction expected timing.
// Revision : 1.0
// ============================================================================
module tb_mem_lsu;

    localparam int ADDR_W     = 17;
    localparam int REG_ADDR_W = 5;
    localparam int MEM_SZ     = 1 << ADDR_W;

    logic                  clk;
    logic                  rst;
    logic                  valid_i;
    logic [1:0]            mem_op_i;
    logic [2:0]            func3_i;
    logic [31:0]           mem_addr_i;
    logic [31:0]           store_data_i;
    logic [REG_ADDR_W-1:0] wd_i;
    logic                  wreg_i;
    logic [31:0]           wdata_i;
    logic                  valid_o;
    logic [REG_ADDR_W-1:0] wd_o;
    logic                  wreg_o;
    logic [31:0]           wdata_o;
    logic                  stall_req_o;
    logic [ADDR_W-1:0]     mem_a_o;
    logic [7:0]            mem_dout_o;
    logic                  mem_wr_o;
    logic [7:0]            mem_din_i;

    logic [7:0] ram     [0:MEM_SZ-1];
    logic [7:0] ref_mem [0:MEM_SZ-1];

    int n_cmp = 0;
    int n_err = 0;

    mem_lsu #(.ADDR_W(ADDR_W), .REG_ADDR_W(REG_ADDR_W)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .mem_op_i(mem_op_i),
        .func3_i(func3_i), .mem_addr_i(mem_addr_i), .store_data_i(store_data_i),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .valid_o(valid_o),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stall_req_o(stall_req_o),
        .mem_a_o(mem_a_o), .mem_dout_o(mem_dout_o), .mem_wr_o(mem_wr_o),
        .mem_din_i(mem_din_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37) + ((i >> 8) * 11));
    endfunction

    // Synchronous byte memory: read data appears the cycle after the address
    initial begin
        mem_din_i = 8'h00;
        for (int i = 0; i < MEM_SZ; i++) ram[i] = init_byte(i);
        forever begin
            @(posedge clk);
            mem_din_i <= ram[mem_a_o];
            if (mem_wr_o) ram[mem_a_o] <= mem_dout_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit load_ok(input logic [2:0] f3);
        return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
        logic [31:0] v;
        v = 32'h0;
        for (int k = 0; k < nbytes(f3); k++)
            v = v | (32'(ref_mem[(a + k) % MEM_SZ]) << (8 * k));
        if (f3 == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    // One instruction from accept to result; hold keeps valid_i up through completion
    task automatic do_op(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [4:0] wd, input logic wr,
                         input logic [31:0] wdat, input bit hold);
        bit ld, st, memok;
        int n, lat, a;
        logic [31:0] exp_data;
        logic exp_wreg;
        ld    = (op == 2'b01) && load_ok(f3);
        st    = (op == 2'b10) && (f3 <= 3'd2);
        memok = ld || st;
        n     = nbytes(f3);
        a     = int'(addr[ADDR_W-1:0]);
        lat   = ld ? n + 2 : (st ? n + 1 : 1);
        if (ld) begin
            exp_data = ref_load(f3, a);
            exp_wreg = wr;
        end else if (st) begin
            exp_data = 32'h0;
            exp_wreg = 1'b0;
        end else begin
            exp_data = wdat;
            exp_wreg = wr && (op != 2'b01) && (op != 2'b10);
        end
        @(posedge clk); #1;
        valid_i = 1'b1; mem_op_i = op; func3_i = f3; mem_addr_i = addr;
        store_data_i = sd; wd_i = wd; wreg_i = wr; wdata_i = wdat;
        @(negedge clk);
        chk("stall_accept", {31'b0, stall_req_o}, {31'b0, memok});
        for (int t = 1; t <= lat; t++) begin
            @(posedge clk); #1;
            if (!hold || !memok) valid_i = 1'b0;
            @(negedge clk);
            if (t < lat) chk("valid_early", {31'b0, valid_o}, 32'd0);
            chk("stall", {31'b0, stall_req_o}, {31'b0, (memok && t < lat)});
            if (st && t <= n) begin
                chk("st_wr", {31'b0, mem_wr_o}, 32'd1);
                chk("st_addr", 32'(mem_a_o), 32'((a + t - 1) % MEM_SZ));
                chk("st_byte", 32'(mem_dout_o), 32'(sd[8*(t-1) +: 8]));
                ref_mem[(a + t - 1) % MEM_SZ] = sd[8*(t-1) +: 8];
            end else if (ld && t <= n) begin
                chk("ld_wr", {31'b0, mem_wr_o}, 32'd0);
                chk("ld_addr", 32'(mem_a_o), 32'((a + t - 1) % MEM_SZ));
            end else if (ld && t == n + 1) begin
                chk("ld_wr", {31'b0, mem_wr_o}, 32'd0);
                if (n < 4) chk("ld_hold_addr", 32'(mem_a_o), 32'((a + n - 1) % MEM_SZ));
            end else begin
                chk("bus_idle_wr", {31'b0, mem_wr_o}, 32'd0);
                chk("bus_idle_addr", 32'(mem_a_o), 32'd0);
            end
            if (t == lat) begin
                chk("valid", {31'b0, valid_o}, 32'd1);
                chk("wd", 32'(wd_o), 32'(wd));
                chk("wreg", {31'b0, wreg_o}, {31'b0, exp_wreg});
                chk("wdata", wdata_o, exp_data);
            end
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(negedge clk);
        chk("idle_valid", {31'b0, valid_o}, 32'd0);
        chk("idle_stall", {31'b0, stall_req_o}, 32'd0);
        chk("idle_wr", {31'b0, mem_wr_o}, 32'd0);
    endtask

    initial begin
        logic [31:0] addd [3];
        logic [1:0]  rop;
        logic [2:0]  rf3;
        logic [31:0] raddr;
        int          sel;

        for (int i = 0; i < MEM_SZ; i++) ref_mem[i] = init_byte(i);
        rst = 1'b0; valid_i = 1'b0; mem_op_i = 2'b00; func3_i = 3'd0;
        mem_addr_i = 32'h0; store_data_i = 32'h0; wd_i = '0; wreg_i = 1'b0; wdata_i = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'b0, valid_o}, 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_wd", 32'(wd_o), 32'd0);
        chk("rst_wr", {31'b0, mem_wr_o}, 32'd0);
        chk("rst_addr", 32'(mem_a_o), 32'd0);
        chk("rst_stall", {31'b0, stall_req_o}, 32'd0);
        rst = 1'b1;

        // LW assembling 11,22,33,44 from 0x100
        do_op(2'b10, 3'd2, 32'h0000_0100, 32'h4433_2211, 5'd4, 1'b1, 32'h0, 1'b0);
        do_op(2'b01, 3'd2, 32'h0000_0100, 32'h0, 5'd5, 1'b1, 32'h0, 1'b0);
        // Sign vs zero extension of 0x80
        do_op(2'b10, 3'd0, 32'h0000_0300, 32'h0000_0080, 5'd1, 1'b1, 32'h0, 1'b0);
        do_op(2'b01, 3'd0, 32'h0000_0300, 32'h0, 5'd6, 1'b1, 32'h0, 1'b0);
        do_op(2'b01, 3'd4, 32'h0000_0300, 32'h0, 5'd7, 1'b1, 32'h0, 1'b0);
        // SH wrapping from the top of memory to 0
        do_op(2'b10, 3'd1, 32'h0001_FFFF, 32'h1234_BEEF, 5'd8, 1'b1, 32'h0, 1'b0);
        do_op(2'b01, 3'd1, 32'h0001_FFFF, 32'h0, 5'd9, 1'b1, 32'h0, 1'b0);
        idle_cycle();

        // Three back-to-back ALU results
        addd[0] = 32'hA000_0001; addd[1] = 32'hB000_0002; addd[2] = 32'hC000_0003;
        @(posedge clk); #1;
        valid_i = 1'b1; mem_op_i = 2'b00; func3_i = 3'd0; wreg_i = 1'b1;
        wd_i = 5'd1; wdata_i = addd[0];
        @(negedge clk);
        chk("b2b_stall0", {31'b0, stall_req_o}, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            if (i < 3) begin
                wd_i = 5'(i + 1); wdata_i = addd[i];
            end else begin
                valid_i = 1'b0;
            end
            @(negedge clk);
            chk("b2b_valid", {31'b0, valid_o}, 32'd1);
            chk("b2b_wd", 32'(wd_o), 32'(i));
            chk("b2b_wdata", wdata_o, addd[i-1]);
            chk("b2b_stall", {31'b0, stall_req_o}, 32'd0);
        end
        idle_cycle();

        // Asynchronous reset in the middle of a LW
        do_op(2'b00, 3'd0, 32'h0, 32'h0, 5'd7, 1'b1, 32'hDEAD_BEEF, 1'b0);
        @(posedge clk); #1;
        valid_i = 1'b1; mem_op_i = 2'b01; func3_i = 3'd2; mem_addr_i = 32'h0000_0200;
        wd_i = 5'd3; wreg_i = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_addr", 32'(mem_a_o), 32'h201);
        chk("pre_rst_wdata", wdata_o, 32'hDEAD_BEEF);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_wr", {31'b0, mem_wr_o}, 32'd0);
        chk("async_rst_addr", 32'(mem_a_o), 32'd0);
        chk("async_rst_stall", {31'b0, stall_req_o}, 32'd0);
        chk("async_rst_valid", {31'b0, valid_o}, 32'd0);
        chk("async_rst_wdata", wdata_o, 32'd0);
        chk("async_rst_wreg", {31'b0, wreg_o}, 32'd0);
        valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        do_op(2'b10, 3'd0, 32'h0000_0400, 32'h0000_005A, 5'd2, 1'b1, 32'h0, 1'b0);
        do_op(2'b01, 3'd4, 32'h0000_0400, 32'h0, 5'd2, 1'b1, 32'h0, 1'b0);

        // LW held through completion, then unsupported load width
        do_op(2'b01, 3'd2, 32'h0000_0100, 32'h0, 5'd10, 1'b1, 32'h0, 1'b1);
        idle_cycle();
        idle_cycle();
        do_op(2'b01, 3'd3, 32'h0000_0100, 32'h0, 5'd11, 1'b1, 32'h1357_9BDF, 1'b0);

        // Randomised mix with addresses biased toward the wrap point
        for (int i = 0; i < 80; i++) begin
            sel = int'($urandom_range(0, 9));
            rf3 = 3'($urandom_range(0, 7));
            if (sel < 4)      rop = 2'b01;
            else if (sel < 7) rop = 2'b10;
            else if (sel < 9) rop = 2'b00;
            else              rop = 2'b11;
            if ($urandom_range(0, 1) == 0) raddr = 32'h0001_FFFC + 32'($urandom_range(0, 3));
            else                           raddr = $urandom;
            do_op(rop, rf3, raddr, $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
